// File: rtl/booth_seq_mul.sv
// -----------------------------------------------------------------------------
// booth_seq_mul
// Iterative radix-4 Booth multiplier. Accepts one signed WIDTH x WIDTH operand
// pair through a valid/ready handshake. Retires one Booth digit per cycle into
// a 2*WIDTH-bit accumulator. Returns the two's-complement product through a
// second valid/ready handshake. One shared recode/partial-product slice is
// reused across all WIDTH/2 digits.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      operand pair offered
//   in_ready      operands accepted this cycle (combinational, state == IDLE)
//   Multiplicant  signed multiplicand, sampled on input handshake
//   Multiplier    signed multiplier, sampled on input handshake
//   Flush         synchronous abort of the operation in flight
//   out_valid     Product valid (registered)
//   out_ready     consumer takes Product
//   Product       signed 2*WIDTH-bit product (registered)
//   Busy          high while in RUN or DONE (registered)
// -----------------------------------------------------------------------------
module booth_seq_mul #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     Multiplicant,
   input  logic [WIDTH-1:0]     Multiplier,
   input  logic                 Flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   Product,
   output logic                 Busy
);

   localparam int unsigned N  = WIDTH / 2;
   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned SW = CW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e          state_q;
   logic [PW-1:0]   m_q;       // sign-extended multiplicand
   logic [WIDTH:0]  r_q;       // {Multiplier, 1'b0} recode register
   logic [PW-1:0]   acc_q;
   logic [CW-1:0]   count_q;

   logic [SW-1:0]   shamt;
   logic [2:0]      digit;
   logic            sel_zero;
   logic            sel_two;
   logic            sel_neg;
   logic [PW-1:0]   mag;
   logic [PW-1:0]   term;
   logic [PW-1:0]   acc_d;
   logic            last_digit;

   assign in_ready   = (state_q == IDLE);
   assign last_digit = (count_q == CW'(N - 1));

   // Digit position 2*count selects R[2*count+2 : 2*count]; also the weight.
   assign shamt = {count_q, 1'b0};
   assign digit = 3'(r_q >> shamt);

   // Radix-4 Booth recode of the current digit.
   always_comb begin
      sel_zero = 1'b0;
      sel_two  = 1'b0;
      sel_neg  = 1'b0;
      unique case (digit)
         3'b001, 3'b010: begin
         end
         3'b011: begin
            sel_two = 1'b1;
         end
         3'b100: begin
            sel_two = 1'b1;
            sel_neg = 1'b1;
         end
         3'b101, 3'b110: begin
            sel_neg = 1'b1;
         end
         default: begin
            sel_zero = 1'b1;
         end
      endcase
   end

   // Weighted partial product; negation is invert plus carry-in of one.
   assign mag   = sel_zero ? '0 : (sel_two ? (m_q << 1) : m_q);
   assign term  = mag << shamt;
   assign acc_d = acc_q + (sel_neg ? ~term : term) + PW'(sel_neg);

   // Control FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         m_q       <= '0;
         r_q       <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         Product   <= '0;
         out_valid <= 1'b0;
         Busy      <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // Flush blocks acceptance in the same cycle.
               if (in_valid && !Flush) begin
                  m_q     <= {{WIDTH{Multiplicant[WIDTH-1]}}, Multiplicant};
                  r_q     <= {Multiplier, 1'b0};
                  acc_q   <= '0;
                  count_q <= '0;
                  Busy    <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (Flush) begin
                  out_valid <= 1'b0;
                  Busy      <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  acc_q   <= acc_d;
                  count_q <= count_q + CW'(1);
                  if (last_digit) begin
                     Product   <= acc_d;
                     out_valid <= 1'b1;
                     state_q   <= DONE;
                  end
               end
            end
            DONE: begin
               // Flush with a simultaneous out handshake still counts as a transfer.
               if (Flush || out_ready) begin
                  out_valid <= 1'b0;
                  Busy      <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               Busy      <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

endmodule
